mem_resp_pipe: RTL

- Multi-cycle data/instruction memory responder: the memory-side end of the CPU's fetch/load/store interface (enable, wr, addr, data_in in; data_out back).
- Replaces the single-cycle memory model with a fixed-latency, fully pipelined responder.
- Accepts one request per cycle and returns read data LATENCY cycles later, qualified by data_valid.
- Instantiated once for instruction fetch and once for data memory.

---
 rtl/mem_pkg.sv | 21 ++
 rtl/mem_resp_pipe_if.sv | 24 ++
 rtl/mem_delay_pipe.sv | 39 +++
 rtl/mem_resp_pipe.sv | 58 +++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the pipelined memory responder.
// A stage record is one slot of the read-response delay line.
package mem_pkg;

  localparam int WORD_WIDTH      = 16;
  localparam int DEFAULT_LATENCY = 4;
  localparam int BUS_ADDR_WIDTH  = 16;

  typedef struct packed {
    logic                  valid;
    logic [WORD_WIDTH-1:0] data;
  } stage_t;

  typedef struct packed {
    logic                      enable;
    logic                      wr;
    logic [BUS_ADDR_WIDTH-1:0] addr;
    logic [WORD_WIDTH-1:0]     data_in;
  } mem_req_t;

endpackage

// File: rtl/mem_resp_pipe_if.sv
// CPU-to-memory request/response bundle.
// The CPU drives the master side and the responder sits on the slave side.
interface mem_resp_pipe_if;
  import mem_pkg::*;

  logic                      enable;
  logic                      wr;
  logic [BUS_ADDR_WIDTH-1:0] addr;
  logic [WORD_WIDTH-1:0]     data_in;
  logic [WORD_WIDTH-1:0]     data_out;
  logic                      data_valid;
  logic                      busy;

  modport master (
    output enable, wr, addr, data_in,
    input  data_out, data_valid, busy
  );

  modport slave (
    input  enable, wr, addr, data_in,
    output data_out, data_valid, busy
  );

endinterface

// File: rtl/mem_delay_pipe.sv
// Fixed-depth shift line of {valid, data} records with an asynchronous clear.
// It presents the oldest record and the OR of every in-flight valid bit.
module mem_delay_pipe
  import mem_pkg::*;
#(
  parameter int LATENCY = DEFAULT_LATENCY
) (
  input  logic   clk,
  input  logic   rst_n,
  input  stage_t i_stage,
  output stage_t o_stage,
  output logic   o_anyValid
);

  stage_t r_stages [LATENCY];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LATENCY; i++) begin
        r_stages[i] <= '0;
      end
    end else begin
      r_stages[0] <= i_stage;
      for (int i = 1; i < LATENCY; i++) begin
        r_stages[i] <= r_stages[i-1];
      end
    end
  end

  assign o_stage = r_stages[LATENCY-1];

  always_comb begin
    o_anyValid = 1'b0;
    for (int i = 0; i < LATENCY; i++) begin
      o_anyValid = o_anyValid | r_stages[i].valid;
    end
  end

endmodule

// File: rtl/mem_resp_pipe.sv
// Fixed-latency, fully pipelined word memory: one request per cycle.
// Reads return LATENCY cycles after acceptance, qualified by data_valid.
module mem_resp_pipe
  import mem_pkg::*;
#(
  parameter int LATENCY    = DEFAULT_LATENCY,
  parameter int ADDR_WIDTH = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  mem_resp_pipe_if.slave  bus
);

  localparam int DEPTH = 2 ** (ADDR_WIDTH - 1);

  mem_req_t              w_req;
  stage_t                w_stageIn;
  stage_t                w_stageOut;
  logic                  w_busy;
  logic [ADDR_WIDTH-2:0] w_wordIdx;
  logic                  w_unusedAddr;

  logic [WORD_WIDTH-1:0] r_mem [DEPTH];

  assign w_req        = {bus.enable, bus.wr, bus.addr, bus.data_in};
  assign w_wordIdx    = w_req.addr[ADDR_WIDTH-1:1];
  assign w_unusedAddr = ^w_req.addr;

  // Array has no reset so that contents survive a mid-run reset.
  always_ff @(posedge clk) begin
    if (w_req.enable && w_req.wr) begin
      r_mem[w_wordIdx] <= w_req.data_in;
    end
  end

  always_comb begin
    w_stageIn = '0;
    if (w_req.enable && !w_req.wr) begin
      w_stageIn.valid = 1'b1;
      w_stageIn.data  = r_mem[w_wordIdx];
    end
  end

  mem_delay_pipe #(
    .LATENCY (LATENCY)
  ) u_delayPipe (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_stage    (w_stageIn),
    .o_stage    (w_stageOut),
    .o_anyValid (w_busy)
  );

  assign bus.data_valid = w_stageOut.valid;
  assign bus.data_out   = w_stageOut.valid ? w_stageOut.data : '0;
  assign bus.busy       = w_busy;

endmodule
